switch_output_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one switch-fabric egress stream between NUM_PORTS depacketizer outputs. Each requester presents 142-bit two-slot flits, one packet at a time. The arbiter locks onto one requester from its head flit until the flit carrying end-of-packet is accepted, so packets never interleave downstream. Orphan flits (non-head flits arriving while no packet is open) are drained and counted.

---
 rtl/switch_fabric_pkg.sv | 61 ++++++
 rtl/rr_arbiter.sv | 28 ++
 rtl/switch_output_arbiter.sv | 147 ++++++++++++++
 tb/tb_switch_output_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_fabric_pkg.sv
// Shared definitions for the switch fabric: flit field layout and arbiter states.
// A flit is two DATA_WIDTH slots plus 14 bits of per-slot control.
package switch_fabric_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    localparam int FLIT_OVERHEAD = 14;

    function automatic int flit_width(input int dw);
        return 2 * dw + FLIT_OVERHEAD;
    endfunction

    // Slot 0 control sits at the top of the flit, slot 1 control just below data0.
    function automatic int slot0_valid_bit(input int dw);
        return flit_width(dw) - 1;
    endfunction

    function automatic int head_bit(input int dw);
        return flit_width(dw) - 2;
    endfunction

    function automatic int eop0_bit(input int dw);
        return flit_width(dw) - 3;
    endfunction

    function automatic int empty0_msb(input int dw);
        return flit_width(dw) - 4;
    endfunction

    function automatic int error0_bit(input int dw);
        return flit_width(dw) - 7;
    endfunction

    function automatic int data0_msb(input int dw);
        return flit_width(dw) - 8;
    endfunction

    function automatic int slot1_valid_bit(input int dw);
        return flit_width(dw) - 8 - dw;
    endfunction

    function automatic int eop1_bit(input int dw);
        return flit_width(dw) - 10 - dw;
    endfunction

    function automatic int empty1_msb(input int dw);
        return flit_width(dw) - 11 - dw;
    endfunction

    function automatic int error1_bit(input int dw);
        return flit_width(dw) - 14 - dw;
    endfunction

    function automatic int data1_msb(input int dw);
        return flit_width(dw) - 15 - dw;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, with wrap.
// Reusable by any fabric scheduler that keeps its own pointer register.
module rr_arbiter #(
    parameter  int NUM_PORTS = 4,
    localparam int PTR_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NUM_PORTS-1:0] gnt
);

    logic [PTR_WIDTH-1:0] idx;
    logic                 found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = PTR_WIDTH'((int'(ptr) + i) % NUM_PORTS);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_output_arbiter.sv
// Packet-granular round-robin arbiter sharing one egress stream between NUM_PORTS requesters.
// Holds a grant from head flit to end-of-packet; non-head flits seen while idle are dropped and counted.
module switch_output_arbiter
    import switch_fabric_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int WIDTH      = 142,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_PORTS*WIDTH-1:0] i_data_in,
    input  logic [NUM_PORTS-1:0]       i_valid_in,
    output logic [NUM_PORTS-1:0]       i_ready_out,
    output logic [WIDTH-1:0]           o_data_out,
    output logic                       o_valid_out,
    input  logic                       o_ready_in,
    output logic [NUM_PORTS-1:0]       o_grant,
    output logic [CNT_WIDTH-1:0]       o_orphan_cnt
);

    localparam int PTR_WIDTH = $clog2(NUM_PORTS);
    localparam int POP_WIDTH = $clog2(NUM_PORTS + 1);
    localparam int SUM_WIDTH = CNT_WIDTH + POP_WIDTH;
    localparam int HEAD_BIT  = head_bit(DATA_WIDTH);
    localparam int EOP0_BIT  = eop0_bit(DATA_WIDTH);
    localparam int EOP1_BIT  = eop1_bit(DATA_WIDTH);

    arb_state_t state, state_next;

    logic [PTR_WIDTH-1:0] rr_ptr, rr_ptr_next, release_ptr;
    logic [NUM_PORTS-1:0] grant_next;
    logic [NUM_PORTS-1:0] head_vec;
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] arb_gnt;
    logic [NUM_PORTS-1:0] orphan_vec;
    logic [NUM_PORTS-1:0] orphan_taken;
    logic [POP_WIDTH-1:0] orphan_pop;
    logic [SUM_WIDTH-1:0] orphan_sum;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0]     granted_flit;
    logic                 granted_valid;
    logic                 granted_last;
    logic                 transfer;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_head
        assign head_vec[p] = i_data_in[p*WIDTH + HEAD_BIT];
    end

    assign req        = i_valid_in & head_vec;
    assign orphan_vec = i_valid_in & ~head_vec;

    rr_arbiter #(
        .NUM_PORTS(NUM_PORTS)
    ) u_rr_arbiter (
        .req(req),
        .ptr(rr_ptr),
        .gnt(arb_gnt)
    );

    // The one-hot grant doubles as the egress mux select, so idle yields zero data.
    always_comb begin
        granted_flit  = '0;
        granted_valid = 1'b0;
        release_ptr   = rr_ptr;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (o_grant[p]) begin
                granted_flit  = i_data_in[p*WIDTH +: WIDTH];
                granted_valid = i_valid_in[p];
                release_ptr   = PTR_WIDTH'((p + 1) % NUM_PORTS);
            end
        end
    end

    assign granted_last = granted_flit[EOP0_BIT] | granted_flit[EOP1_BIT];
    assign transfer     = (state == LOCKED) && granted_valid && o_ready_in;

    // Outputs are forced low while reset is held so the upstream sees no accepts mid-reset.
    always_comb begin
        state_next   = state;
        grant_next   = o_grant;
        rr_ptr_next  = rr_ptr;
        o_data_out   = '0;
        o_valid_out  = 1'b0;
        i_ready_out  = '0;
        orphan_taken = '0;

        case (state)
            IDLE: begin
                orphan_taken = orphan_vec;
                if (reset) begin
                    i_ready_out = orphan_vec;
                end
                if (|req) begin
                    state_next = LOCKED;
                    grant_next = arb_gnt;
                end
            end
            LOCKED: begin
                if (reset) begin
                    o_data_out  = granted_flit;
                    o_valid_out = granted_valid;
                    i_ready_out = o_grant & {NUM_PORTS{o_ready_in}};
                end
                if (transfer && granted_last) begin
                    state_next  = IDLE;
                    grant_next  = '0;
                    rr_ptr_next = release_ptr;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    // Several orphans can drop in one cycle; add their popcount and clamp at all-ones.
    always_comb begin
        orphan_pop = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            orphan_pop = orphan_pop + POP_WIDTH'(orphan_taken[p]);
        end
        orphan_sum = SUM_WIDTH'(o_orphan_cnt) + SUM_WIDTH'(orphan_pop);
        if (orphan_sum > SUM_WIDTH'({CNT_WIDTH{1'b1}})) begin
            cnt_next = '1;
        end else begin
            cnt_next = orphan_sum[CNT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            o_grant      <= '0;
            o_orphan_cnt <= '0;
        end else begin
            state        <= state_next;
            rr_ptr       <= rr_ptr_next;
            o_grant      <= grant_next;
            o_orphan_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_switch_output_arbiter.sv
// Self-checking bench for switch_output_arbiter: vector table plus handshake-driven packet sequences.
// Per-port source queues feed the DUT; a scoreboard queue holds the flits expected at the egress.
module tb_switch_output_arbiter;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int FW = 142;
    localparam int CW = 8;
    localparam int W  = FW - 1;

    typedef logic [FW-1:0] flit_t;

    typedef struct packed {
        logic [NP-1:0] grant;
        flit_t         flit;
    } xfer_t;

    typedef struct {
        logic [NP-1:0] valid;
        logic [NP-1:0] head;
        logic [NP-1:0] expReady;
        logic [NP-1:0] expGrant;
        logic [CW-1:0] expCnt;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic [NP*FW-1:0] data_in;
    logic [NP-1:0]    valid_in;
    logic [NP-1:0]    ready_out;
    logic [FW-1:0]    data_out;
    logic             valid_out;
    logic             ready_in;
    logic [NP-1:0]    grant;
    logic [CW-1:0]    orphan_cnt;

    flit_t src_q [NP][$];
    xfer_t sb[$];
    vec_t  vecs[8];

    int checks = 0;
    int passes = 0;
    int xfers  = 0;
    bit direct = 0;

    switch_output_arbiter #(
        .NUM_PORTS(NP),
        .DATA_WIDTH(DW),
        .WIDTH(FW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .i_data_in(data_in),
        .i_valid_in(valid_in),
        .i_ready_out(ready_out),
        .o_data_out(data_out),
        .o_valid_out(valid_out),
        .o_ready_in(ready_in),
        .o_grant(grant),
        .o_orphan_cnt(orphan_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Field positions are taken straight from the flit layout with W = FW-1.
    function automatic flit_t mkFlit(input logic head, input logic eop0, input logic eop1,
                                     input logic [15:0] tag);
        flit_t f;
        f = '0;
        f[W]                  = 1'b1;
        f[W-1]                = head;
        f[W-2]                = eop0;
        f[W-7 -: DW]          = {tag, ~tag, tag, 16'hC0DE};
        f[W-7-DW]             = 1'b1;
        f[W-9-DW]             = eop1;
        f[W-14-DW -: DW]      = {4{tag ^ 16'h5A5A}};
        return f;
    endfunction

    function automatic bit srcBusy();
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [FW-1:0] actual,
                               input logic [FW-1:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic expectXfer(input logic [NP-1:0] g, input flit_t f);
        xfer_t e;
        e.grant = g;
        e.flit  = f;
        sb.push_back(e);
    endtask

    task automatic drive();
        if (!direct) begin
            for (int p = 0; p < NP; p++) begin
                if (src_q[p].size() != 0) begin
                    valid_in[p]          = 1'b1;
                    data_in[p*FW +: FW]  = src_q[p][0];
                end else begin
                    valid_in[p]          = 1'b0;
                    data_in[p*FW +: FW]  = '0;
                end
            end
        end
    endtask

    task automatic monitor();
        xfer_t e;
        if (valid_out && ready_in) begin
            xfers++;
            if (sb.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_xfer: got %0h, expected no transfer", data_out);
            end else begin
                e = sb.pop_front();
                checkOutput("xfer_data", data_out, e.flit);
                checkOutput("xfer_grant", FW'(grant), FW'(e.grant));
            end
        end
    endtask

    // One clock: monitor at the falling edge, then retire accepted flits and re-drive sources.
    task automatic cycle();
        logic [NP-1:0] acc;
        @(negedge clk);
        monitor();
        acc = valid_in & ready_out;
        @(posedge clk);
        #1;
        if (!direct) begin
            for (int p = 0; p < NP; p++) begin
                if (acc[p]) void'(src_q[p].pop_front());
            end
        end
        drive();
        #1;
    endtask

    task automatic resetDut();
        direct   = 1'b0;
        rst_n    = 1'b0;
        ready_in = 1'b1;
        valid_in = '0;
        data_in  = '0;
        for (int p = 0; p < NP; p++) src_q[p].delete();
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while ((srcBusy() || grant != '0) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (n < budget) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s_drain: got busy after %0d cycles, expected idle", name, n);
        end
        checkOutput("sb_empty", FW'(sb.size()), FW'(0));
    endtask

    task automatic applyStimulus(input vec_t v);
        for (int p = 0; p < NP; p++) begin
            data_in[p*FW +: FW] = mkFlit(v.head[p], 1'b0, 1'b0, 16'(16'h0100 + p));
        end
        valid_in = v.valid;
        #1;
    endtask

    initial begin
        logic [NP-1:0] expG;
        flit_t         expD;
        flit_t         f [4];
        int            x0;

        vecs[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'd0};
        vecs[1] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 8'd0};
        vecs[2] = '{4'b1010, 4'b1000, 4'b0010, 4'b1000, 8'd1};
        vecs[3] = '{4'b1111, 4'b1111, 4'b0000, 4'b0001, 8'd0};
        vecs[4] = '{4'b1001, 4'b0000, 4'b1001, 4'b0000, 8'd2};
        vecs[5] = '{4'b0110, 4'b0010, 4'b0100, 4'b0010, 8'd1};
        vecs[6] = '{4'b1111, 4'b0110, 4'b1001, 4'b0010, 8'd2};
        vecs[7] = '{4'b0010, 4'b1011, 4'b0000, 4'b0010, 8'd0};

        // Held reset with valid orphans present: every output must stay low.
        direct   = 1'b1;
        rst_n    = 1'b0;
        ready_in = 1'b1;
        for (int p = 0; p < NP; p++) data_in[p*FW +: FW] = mkFlit(1'b0, 1'b0, 1'b0, 16'(p));
        valid_in = '1;
        #23;
        checkOutput("rst_ready", FW'(ready_out), FW'(0));
        checkOutput("rst_valid", FW'(valid_out), FW'(0));
        checkOutput("rst_data", data_out, '0);
        checkOutput("rst_grant", FW'(grant), FW'(0));
        checkOutput("rst_cnt", FW'(orphan_cnt), FW'(0));

        $display("[TB] vector table");
        for (int i = 0; i < 8; i++) begin
            resetDut();
            direct   = 1'b1;
            ready_in = 1'b0;
            applyStimulus(vecs[i]);
            checkOutput("tbl_ready", FW'(ready_out), FW'(vecs[i].expReady));
            checkOutput("tbl_idle_valid", FW'(valid_out), FW'(0));
            @(posedge clk);
            #2;
            expG = vecs[i].expGrant;
            expD = '0;
            for (int p = 0; p < NP; p++) begin
                if (expG[p]) expD = mkFlit(vecs[i].head[p], 1'b0, 1'b0, 16'(16'h0100 + p));
            end
            checkOutput("tbl_grant", FW'(grant), FW'(expG));
            checkOutput("tbl_cnt", FW'(orphan_cnt), FW'(vecs[i].expCnt));
            checkOutput("tbl_data", data_out, expD);
            checkOutput("tbl_valid", FW'(valid_out), FW'(|expG));
        end

        $display("[TB] single request on port 2");
        resetDut();
        f[0] = mkFlit(1'b1, 1'b0, 1'b0, 16'h2000);
        f[1] = mkFlit(1'b0, 1'b0, 1'b0, 16'h2001);
        f[2] = mkFlit(1'b0, 1'b0, 1'b1, 16'h2002);
        for (int k = 0; k < 3; k++) begin
            src_q[2].push_back(f[k]);
            expectXfer(4'b0100, f[k]);
        end
        drive();
        #1;
        x0 = xfers;
        checkOutput("t1_c0_grant", FW'(grant), FW'(0));
        checkOutput("t1_c0_valid", FW'(valid_out), FW'(0));
        for (int c = 1; c <= 4; c++) begin
            cycle();
            checkOutput("t1_grant", FW'(grant), FW'((c <= 3) ? 4'b0100 : 4'b0000));
        end
        checkOutput("t1_xfers", FW'(xfers - x0), FW'(3));
        src_q[0].push_back(mkFlit(1'b1, 1'b1, 1'b0, 16'h2100));
        src_q[3].push_back(mkFlit(1'b1, 1'b1, 1'b0, 16'h2103));
        expectXfer(4'b1000, mkFlit(1'b1, 1'b1, 1'b0, 16'h2103));
        expectXfer(4'b0001, mkFlit(1'b1, 1'b1, 1'b0, 16'h2100));
        drive();
        #1;
        cycle();
        checkOutput("t1_ptr3_grant", FW'(grant), FW'(4'b1000));
        cycle();
        checkOutput("t1_bubble", FW'(grant), FW'(0));
        cycle();
        checkOutput("t1_wrap_grant", FW'(grant), FW'(4'b0001));
        waitDrain("t1", 20);

        $display("[TB] fairness");
        resetDut();
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < NP; p++) begin
                src_q[p].push_back(mkFlit(1'b1, 1'b0, 1'b0, 16'(16'h3000 + 16*r + 2*p)));
                src_q[p].push_back(mkFlit(1'b0, 1'b0, 1'b1, 16'(16'h3001 + 16*r + 2*p)));
                expectXfer(4'(1 << p), mkFlit(1'b1, 1'b0, 1'b0, 16'(16'h3000 + 16*r + 2*p)));
                expectXfer(4'(1 << p), mkFlit(1'b0, 1'b0, 1'b1, 16'(16'h3001 + 16*r + 2*p)));
            end
        end
        drive();
        #1;
        x0 = xfers;
        for (int c = 0; c <= 13; c++) begin
            if (c == 12) checkOutput("t2_round_xfers", FW'(xfers - x0), FW'(8));
            expG = (c % 3 == 0) ? 4'b0000 : 4'(1 << ((c / 3) % 4));
            checkOutput("t2_grant", FW'(grant), FW'(expG));
            if (c < 13) cycle();
        end
        waitDrain("t2", 40);

        $display("[TB] backpressure on port 1");
        resetDut();
        f[0] = mkFlit(1'b1, 1'b0, 1'b0, 16'h4000);
        f[1] = mkFlit(1'b0, 1'b0, 1'b0, 16'h4001);
        f[2] = mkFlit(1'b0, 1'b0, 1'b1, 16'h4002);
        for (int k = 0; k < 3; k++) begin
            src_q[1].push_back(f[k]);
            expectXfer(4'b0010, f[k]);
        end
        drive();
        #1;
        cycle();
        cycle();
        ready_in = 1'b0;
        src_q[3].push_back(mkFlit(1'b1, 1'b1, 1'b0, 16'h4300));
        expectXfer(4'b1000, mkFlit(1'b1, 1'b1, 1'b0, 16'h4300));
        drive();
        #1;
        for (int s = 0; s < 5; s++) begin
            checkOutput("t3_stall_data", data_out, f[1]);
            checkOutput("t3_stall_ready", FW'(ready_out), FW'(0));
            checkOutput("t3_stall_grant", FW'(grant), FW'(4'b0010));
            cycle();
        end
        ready_in = 1'b1;
        #1;
        checkOutput("t3_resume_ready", FW'(ready_out), FW'(4'b0010));
        cycle();
        cycle();
        checkOutput("t3_release", FW'(grant), FW'(0));
        cycle();
        checkOutput("t3_next_grant", FW'(grant), FW'(4'b1000));
        waitDrain("t3", 20);

        $display("[TB] orphans");
        resetDut();
        for (int k = 0; k < 2; k++) begin
            src_q[0].push_back(mkFlit(1'b0, 1'b0, 1'b0, 16'(16'h5000 + k)));
            src_q[3].push_back(mkFlit(1'b0, 1'b0, 1'b0, 16'(16'h5300 + k)));
        end
        drive();
        #1;
        checkOutput("t4_ready", FW'(ready_out), FW'(4'b1001));
        cycle();
        checkOutput("t4_ready2", FW'(ready_out), FW'(4'b1001));
        checkOutput("t4_cnt2", FW'(orphan_cnt), FW'(2));
        cycle();
        checkOutput("t4_cnt4", FW'(orphan_cnt), FW'(4));
        checkOutput("t4_drained", FW'(ready_out), FW'(0));
        for (int k = 0; k < 130; k++) begin
            src_q[1].push_back(mkFlit(1'b0, 1'b0, 1'b0, 16'(k)));
            src_q[2].push_back(mkFlit(1'b0, 1'b0, 1'b1, 16'(k)));
        end
        drive();
        #1;
        repeat (125) cycle();
        checkOutput("t4_cnt254", FW'(orphan_cnt), FW'(254));
        cycle();
        checkOutput("t4_cnt_sat", FW'(orphan_cnt), FW'(255));
        waitDrain("t4", 20);
        checkOutput("t4_cnt_hold", FW'(orphan_cnt), FW'(255));

        $display("[TB] single-flit packet");
        resetDut();
        src_q[0].push_back(mkFlit(1'b1, 1'b1, 1'b0, 16'h6000));
        expectXfer(4'b0001, mkFlit(1'b1, 1'b1, 1'b0, 16'h6000));
        src_q[1].push_back(mkFlit(1'b1, 1'b0, 1'b0, 16'h6100));
        src_q[1].push_back(mkFlit(1'b0, 1'b0, 1'b1, 16'h6101));
        expectXfer(4'b0010, mkFlit(1'b1, 1'b0, 1'b0, 16'h6100));
        expectXfer(4'b0010, mkFlit(1'b0, 1'b0, 1'b1, 16'h6101));
        drive();
        #1;
        cycle();
        checkOutput("t5_grant0", FW'(grant), FW'(4'b0001));
        cycle();
        checkOutput("t5_release", FW'(grant), FW'(0));
        checkOutput("t5_idle_ready", FW'(ready_out), FW'(0));
        cycle();
        checkOutput("t5_grant1", FW'(grant), FW'(4'b0010));
        waitDrain("t5", 20);

        $display("[TB] reset mid-packet");
        resetDut();
        f[0] = mkFlit(1'b1, 1'b0, 1'b0, 16'h7000);
        f[1] = mkFlit(1'b0, 1'b0, 1'b0, 16'h7001);
        f[2] = mkFlit(1'b0, 1'b0, 1'b0, 16'h7002);
        f[3] = mkFlit(1'b0, 1'b0, 1'b1, 16'h7003);
        for (int k = 0; k < 4; k++) src_q[2].push_back(f[k]);
        expectXfer(4'b0100, f[0]);
        expectXfer(4'b0100, f[1]);
        drive();
        #1;
        repeat (3) cycle();
        checkOutput("t6_pre_data", data_out, f[2]);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_grant", FW'(grant), FW'(0));
        checkOutput("t6_rst_valid", FW'(valid_out), FW'(0));
        checkOutput("t6_rst_data", data_out, '0);
        checkOutput("t6_rst_ready", FW'(ready_out), FW'(0));
        cycle();
        rst_n = 1'b1;
        #1;
        checkOutput("t6_orphan_ready", FW'(ready_out), FW'(4'b0100));
        cycle();
        checkOutput("t6_cnt1", FW'(orphan_cnt), FW'(1));
        cycle();
        checkOutput("t6_cnt2", FW'(orphan_cnt), FW'(2));
        checkOutput("t6_grant", FW'(grant), FW'(0));
        waitDrain("t6", 10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
